// File: rtl/phys_reg_free_list_pkg.sv
// Shared rename-stage types: physical tag, RRU/ROB packets to the free list.
package phys_reg_free_list_pkg;

  localparam int unsigned NUM_PREGS  = 64;
  localparam int unsigned NUM_AREGS  = 32;
  localparam int unsigned PHYS_TAG_W = $clog2(NUM_PREGS);

  typedef logic [PHYS_TAG_W-1:0] PhysRegTag;

  typedef struct packed {
    logic [1:0] allocReq;
  } RruToFreeList;

  typedef struct packed {
    logic [1:0] relValid;
    PhysRegTag  relTag0;
    PhysRegTag  relTag1;
  } RobToFreeList;

  // Number of set lanes in a two-lane valid vector.
  function automatic logic [1:0] popCount2(input logic [1:0] v);
    return {v[1] & v[0], v[1] ^ v[0]};
  endfunction

endpackage

// File: rtl/phys_reg_free_list_ring.sv
// Free-list storage: DEPTH-entry ring, two reads at head, two in-order writes at tail.
module phys_reg_free_list_ring
  import phys_reg_free_list_pkg::*;
#(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned TAG_W = 6,
  parameter int unsigned BASE  = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [1:0]       rdAdv,
  input  logic [1:0]       wrEn,
  input  logic [TAG_W-1:0] wrTag0,
  input  logic [TAG_W-1:0] wrTag1,
  output logic [TAG_W-1:0] rdTag0_c,
  output logic [TAG_W-1:0] rdTag1_c
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [TAG_W-1:0] ring [DEPTH];
  logic [PTR_W-1:0] headQ;
  logic [PTR_W-1:0] tailQ;
  logic [PTR_W-1:0] headPlus1;
  logic [PTR_W-1:0] wrAddr1;

  // Depth need not be a power of two, so wrap by subtraction.
  function automatic logic [PTR_W-1:0] wrapAdd(input logic [PTR_W-1:0] p,
                                               input logic [1:0]       k);
    logic [PTR_W:0] s;
    s = {1'b0, p} + (PTR_W+1)'(k);
    if (s >= (PTR_W+1)'(DEPTH)) s = s - (PTR_W+1)'(DEPTH);
    return s[PTR_W-1:0];
  endfunction

  always_comb begin
    headPlus1 = wrapAdd(headQ, 2'd1);
    wrAddr1   = wrEn[0] ? wrapAdd(tailQ, 2'd1) : tailQ;
    rdTag0_c  = ring[headQ];
    rdTag1_c  = ring[headPlus1];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        ring[i] <= TAG_W'(BASE + i);
      end
      headQ <= '0;
      tailQ <= '0;
    end else begin
      if (wrEn[0]) ring[tailQ]   <= wrTag0;
      if (wrEn[1]) ring[wrAddr1] <= wrTag1;
      headQ <= wrapAdd(headQ, rdAdv);
      tailQ <= wrapAdd(tailQ, popCount2(wrEn));
    end
  end

endmodule

// File: rtl/phys_reg_free_list.sv
// Rename-stage physical register free list: all-or-nothing 2-lane allocate, 2-lane release.
// Define PHYS_FREE_LIST_CHECK_EN to track in-list tags and flag bad releases on dbl_free_err.
module phys_reg_free_list
  import phys_reg_free_list_pkg::*;
#(
  parameter int unsigned NUM_PREGS = phys_reg_free_list_pkg::NUM_PREGS,
  parameter int unsigned NUM_AREGS = phys_reg_free_list_pkg::NUM_AREGS
) (
  input  logic                                     CLK,
  input  logic                                     RST,
  input  logic [1:0]                               alloc_req,
  output logic                                     alloc_gnt,
  output logic [$clog2(NUM_PREGS)-1:0]             alloc_tag0,
  output logic [$clog2(NUM_PREGS)-1:0]             alloc_tag1,
  input  logic [1:0]                               rel_valid,
  input  logic [$clog2(NUM_PREGS)-1:0]             rel_tag0,
  input  logic [$clog2(NUM_PREGS)-1:0]             rel_tag1,
  output logic [$clog2(NUM_PREGS-NUM_AREGS+1)-1:0] free_count,
  output logic                                     empty,
  output logic                                     dbl_free_err
);

  localparam int unsigned DEPTH = NUM_PREGS - NUM_AREGS;
  localparam int unsigned TAG_W = $clog2(NUM_PREGS);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [CNT_W-1:0] countQ;
  logic [CNT_W-1:0] countNext;
  logic             emptyQ;
  logic [1:0]       reqCnt;
  logic [1:0]       relCnt;
  logic [1:0]       allocCnt;
  logic [1:0]       relFire;
  logic [1:0]       relFireCnt;
  logic             allocFire;
  logic             overflow;
  logic             relErr;
  logic [TAG_W-1:0] ringTag0;
  logic [TAG_W-1:0] ringTag1;

  phys_reg_free_list_ring #(
    .DEPTH (DEPTH),
    .TAG_W (TAG_W),
    .BASE  (NUM_AREGS)
  ) u_ring (
    .CLK      (CLK),
    .RST      (RST),
    .rdAdv    (allocCnt),
    .wrEn     (relFire),
    .wrTag0   (rel_tag0),
    .wrTag1   (rel_tag1),
    .rdTag0_c (ringTag0),
    .rdTag1_c (ringTag1)
  );

`ifdef PHYS_FREE_LIST_CHECK_EN
  logic [NUM_PREGS-1:0] inListQ;
  logic                 errQ;
  logic                 laneBad0;
  logic                 laneBad1;
  logic                 sameTag;
`endif

  // Grant uses current count only; same-cycle releases are not bypassed.
  always_comb begin
    reqCnt     = popCount2(alloc_req);
    relCnt     = popCount2(rel_valid);
    alloc_gnt  = RST || (countQ >= CNT_W'(reqCnt));
    allocFire  = alloc_gnt && !RST;
    allocCnt   = allocFire ? reqCnt : 2'd0;
    alloc_tag0 = ringTag0;
    alloc_tag1 = alloc_req[0] ? ringTag1 : ringTag0;
    overflow   = ({1'b0, countQ} + (CNT_W+1)'(relCnt)) > (CNT_W+1)'(DEPTH);
    relErr     = overflow;
`ifdef PHYS_FREE_LIST_CHECK_EN
    laneBad0 = rel_valid[0] && ((32'(rel_tag0) < NUM_AREGS) || (32'(rel_tag0) >= NUM_PREGS)
                                || inListQ[rel_tag0]);
    laneBad1 = rel_valid[1] && ((32'(rel_tag1) < NUM_AREGS) || (32'(rel_tag1) >= NUM_PREGS)
                                || inListQ[rel_tag1]);
    sameTag  = (&rel_valid) && (rel_tag0 == rel_tag1);
    relErr   = overflow || laneBad0 || laneBad1 || sameTag;
`endif
    relFire    = (relErr || RST) ? 2'b00 : rel_valid;
    relFireCnt = popCount2(relFire);
    countNext  = countQ - CNT_W'(allocCnt) + CNT_W'(relFireCnt);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      countQ <= CNT_W'(DEPTH);
      emptyQ <= 1'b0;
    end else begin
      countQ <= countNext;
      emptyQ <= (countNext == '0);
    end
  end

`ifdef PHYS_FREE_LIST_CHECK_EN
  // In-list vector: clear on allocate, set on accepted release; error is sticky.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < int'(NUM_PREGS); i++) begin
        inListQ[i] <= (i >= int'(NUM_AREGS));
      end
      errQ <= 1'b0;
    end else begin
      if (relErr) errQ <= 1'b1;
      if (allocFire && alloc_req[0]) inListQ[alloc_tag0] <= 1'b0;
      if (allocFire && alloc_req[1]) inListQ[alloc_tag1] <= 1'b0;
      if (relFire[0]) inListQ[rel_tag0] <= 1'b1;
      if (relFire[1]) inListQ[rel_tag1] <= 1'b1;
    end
  end

  assign dbl_free_err = errQ;
`else
  assign dbl_free_err = 1'b0;
`endif

  assign free_count = countQ;
  assign empty      = emptyQ;

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Self-checking bench for phys_reg_free_list: directed scenarios plus random traffic vs a FIFO model.
module tb_phys_reg_free_list;

  localparam int unsigned NUM_PREGS = 64;
  localparam int unsigned NUM_AREGS = 32;
  localparam int unsigned DEPTH     = NUM_PREGS - NUM_AREGS;
  localparam int unsigned TAG_W     = 6;
  localparam int unsigned CNT_W     = 6;

  logic             CLK;
  logic             RST;
  logic [1:0]       alloc_req;
  logic             alloc_gnt;
  logic [TAG_W-1:0] alloc_tag0;
  logic [TAG_W-1:0] alloc_tag1;
  logic [1:0]       rel_valid;
  logic [TAG_W-1:0] rel_tag0;
  logic [TAG_W-1:0] rel_tag1;
  logic [CNT_W-1:0] free_count;
  logic             empty;
  logic             dbl_free_err;

  phys_reg_free_list #(
    .NUM_PREGS (NUM_PREGS),
    .NUM_AREGS (NUM_AREGS)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .alloc_req    (alloc_req),
    .alloc_gnt    (alloc_gnt),
    .alloc_tag0   (alloc_tag0),
    .alloc_tag1   (alloc_tag1),
    .rel_valid    (rel_valid),
    .rel_tag0     (rel_tag0),
    .rel_tag1     (rel_tag1),
    .free_count   (free_count),
    .empty        (empty),
    .dbl_free_err (dbl_free_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model: free list is a FIFO of tags; outq holds tags handed out.
  int   fq[$];
  int   outq[$];
  bit   mInList[NUM_PREGS];
  bit   mErr;
  logic expGnt;
  int   expTag0;
  int   expTag1;
  logic obsGnt;
  logic [TAG_W-1:0] obsTag0;
  logic [TAG_W-1:0] obsTag1;
  int   checks;
  int   errors;

  task automatic model_reset();
    fq.delete();
    outq.delete();
    for (int i = 0; i < int'(NUM_PREGS); i++) mInList[i] = (i >= int'(NUM_AREGS));
    for (int i = 0; i < int'(DEPTH); i++) fq.push_back(int'(NUM_AREGS) + i);
    mErr = 1'b0;
  endtask

  task automatic remove_out(input int t);
    for (int k = 0; k < outq.size(); k++) begin
      if (outq[k] == t) begin
        outq.delete(k);
        break;
      end
    end
  endtask

  task automatic do_reset(input logic [1:0] req);
    RST       = 1'b1;
    alloc_req = req;
    rel_valid = 2'b11;
    rel_tag0  = '0;
    rel_tag1  = '0;
    @(negedge CLK);
    obsGnt = alloc_gnt;
    @(posedge CLK);
    #1;
    RST       = 1'b0;
    alloc_req = 2'b00;
    rel_valid = 2'b00;
    model_reset();
  endtask

  // One clock: drive, sample combinational outputs mid-cycle, then advance the model.
  task automatic cycle(input logic [1:0] req, input logic [1:0] rv, input int t0, input int t1);
    int pcq;
    int pcr;
    bit relOk;
    int tg;
    alloc_req = req;
    rel_valid = rv;
    rel_tag0  = TAG_W'(t0);
    rel_tag1  = TAG_W'(t1);
    pcq = int'(req[0]) + int'(req[1]);
    pcr = int'(rv[0]) + int'(rv[1]);
    expGnt  = (fq.size() >= pcq);
    expTag0 = (fq.size() > 0) ? fq[0] : -1;
    expTag1 = req[0] ? ((fq.size() > 1) ? fq[1] : -1) : expTag0;
    relOk = (fq.size() + pcr) <= int'(DEPTH);
`ifdef PHYS_FREE_LIST_CHECK_EN
    if (rv[0] && (t0 < int'(NUM_AREGS) || mInList[t0])) relOk = 1'b0;
    if (rv[1] && (t1 < int'(NUM_AREGS) || mInList[t1])) relOk = 1'b0;
    if (rv == 2'b11 && t0 == t1) relOk = 1'b0;
    if (!relOk) mErr = 1'b1;
`endif
    @(negedge CLK);
    obsGnt  = alloc_gnt;
    obsTag0 = alloc_tag0;
    obsTag1 = alloc_tag1;
    @(posedge CLK);
    #1;
    if (expGnt) begin
      for (int k = 0; k < pcq; k++) begin
        tg = fq.pop_front();
        outq.push_back(tg);
        mInList[tg] = 1'b0;
      end
    end
    if (relOk) begin
      if (rv[0]) begin fq.push_back(t0); mInList[t0] = 1'b1; remove_out(t0); end
      if (rv[1]) begin fq.push_back(t1); mInList[t1] = 1'b1; remove_out(t1); end
    end
    alloc_req = 2'b00;
    rel_valid = 2'b00;
  endtask

  task automatic test_reset();
    do_reset(2'b11);
    checks++;
    if (obsGnt !== 1'b1) begin errors++; $display("FAIL rst_gnt got %b want 1", obsGnt); end
    checks++;
    if (free_count !== CNT_W'(DEPTH)) begin
      errors++; $display("FAIL rst_count got %0d want %0d", free_count, DEPTH);
    end
    checks++;
    if (empty !== 1'b0) begin errors++; $display("FAIL rst_empty got %b want 0", empty); end
    checks++;
    if (dbl_free_err !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", dbl_free_err); end
  endtask

  task automatic test_first_alloc();
    do_reset(2'b00);
    cycle(2'b11, 2'b00, 0, 0);
    checks++;
    if (obsGnt !== 1'b1 || obsTag0 !== TAG_W'(32) || obsTag1 !== TAG_W'(33)) begin
      errors++; $display("FAIL first_alloc got gnt=%b t0=%0d t1=%0d want 1/32/33", obsGnt, obsTag0, obsTag1);
    end
    checks++;
    if (free_count !== CNT_W'(30)) begin errors++; $display("FAIL first_count got %0d want 30", free_count); end
  endtask

  task automatic test_exhaust();
    do_reset(2'b00);
    for (int i = 0; i < 32; i++) begin
      cycle(2'b01, 2'b00, 0, 0);
      checks++;
      if (obsGnt !== 1'b1 || obsTag0 !== TAG_W'(32 + i)) begin
        errors++; $display("FAIL exhaust_tag%0d got gnt=%b t0=%0d want 1/%0d", i, obsGnt, obsTag0, 32 + i);
      end
    end
    checks++;
    if (empty !== 1'b1 || free_count !== '0) begin
      errors++; $display("FAIL exhaust_empty got empty=%b cnt=%0d want 1/0", empty, free_count);
    end
    cycle(2'b01, 2'b01, 40, 0);
    checks++;
    if (obsGnt !== 1'b0) begin errors++; $display("FAIL empty_gnt got %b want 0", obsGnt); end
    checks++;
    if (free_count !== CNT_W'(1) || empty !== 1'b0) begin
      errors++; $display("FAIL empty_release got cnt=%0d empty=%b want 1/0", free_count, empty);
    end
    cycle(2'b01, 2'b00, 0, 0);
    checks++;
    if (obsGnt !== 1'b1 || obsTag0 !== TAG_W'(40)) begin
      errors++; $display("FAIL realloc got gnt=%b t0=%0d want 1/40", obsGnt, obsTag0);
    end
  endtask

  task automatic test_no_bypass();
    cycle(2'b00, 2'b01, 41, 0);
    checks++;
    if (free_count !== CNT_W'(1)) begin errors++; $display("FAIL nb_count1 got %0d want 1", free_count); end
    cycle(2'b11, 2'b11, 42, 43);
    checks++;
    if (obsGnt !== 1'b0) begin errors++; $display("FAIL nb_gnt got %b want 0", obsGnt); end
    checks++;
    if (free_count !== CNT_W'(3)) begin errors++; $display("FAIL nb_count3 got %0d want 3", free_count); end
    cycle(2'b11, 2'b00, 0, 0);
    checks++;
    if (obsTag0 !== TAG_W'(41) || obsTag1 !== TAG_W'(42)) begin
      errors++; $display("FAIL nb_tags got %0d/%0d want 41/42", obsTag0, obsTag1);
    end
    cycle(2'b10, 2'b00, 0, 0);
    checks++;
    if (obsGnt !== 1'b1 || obsTag1 !== TAG_W'(43)) begin
      errors++; $display("FAIL lane1_only got gnt=%b t1=%0d want 1/43", obsGnt, obsTag1);
    end
  endtask

  task automatic test_wrap();
    do_reset(2'b00);
    for (int i = 0; i < 15; i++) cycle(2'b11, 2'b00, 0, 0);
    cycle(2'b01, 2'b00, 0, 0);
    checks++;
    if (free_count !== CNT_W'(1)) begin errors++; $display("FAIL wrap_count got %0d want 1", free_count); end
    for (int i = 0; i < 15; i++) cycle(2'b00, 2'b11, 62 - 2 * i, 61 - 2 * i);
    cycle(2'b00, 2'b01, 32, 0);
    checks++;
    if (free_count !== CNT_W'(32)) begin errors++; $display("FAIL wrap_full got %0d want 32", free_count); end
    cycle(2'b11, 2'b00, 0, 0);
    checks++;
    if (obsTag0 !== TAG_W'(63) || obsTag1 !== TAG_W'(62)) begin
      errors++; $display("FAIL wrap_tags1 got %0d/%0d want 63/62", obsTag0, obsTag1);
    end
    cycle(2'b11, 2'b00, 0, 0);
    checks++;
    if (obsTag0 !== TAG_W'(61) || obsTag1 !== TAG_W'(60)) begin
      errors++; $display("FAIL wrap_tags2 got %0d/%0d want 61/60", obsTag0, obsTag1);
    end
  endtask

  task automatic test_overflow();
    do_reset(2'b00);
    cycle(2'b00, 2'b01, 20, 0);
    checks++;
    if (free_count !== CNT_W'(32)) begin errors++; $display("FAIL ovf_count got %0d want 32", free_count); end
    checks++;
    if (dbl_free_err !== mErr) begin errors++; $display("FAIL ovf_err got %b want %b", dbl_free_err, mErr); end
    cycle(2'b01, 2'b00, 0, 0);
    checks++;
    if (obsTag0 !== TAG_W'(32)) begin errors++; $display("FAIL ovf_tag got %0d want 32", obsTag0); end
  endtask

`ifdef PHYS_FREE_LIST_CHECK_EN
  task automatic test_check();
    do_reset(2'b00);
    cycle(2'b01, 2'b00, 0, 0);
    cycle(2'b00, 2'b01, 45, 0);
    checks++;
    if (dbl_free_err !== 1'b1 || free_count !== CNT_W'(31)) begin
      errors++; $display("FAIL chk_inlist got err=%b cnt=%0d want 1/31", dbl_free_err, free_count);
    end
    cycle(2'b00, 2'b01, 5, 0);
    checks++;
    if (dbl_free_err !== 1'b1 || free_count !== CNT_W'(31)) begin
      errors++; $display("FAIL chk_areg got err=%b cnt=%0d want 1/31", dbl_free_err, free_count);
    end
    cycle(2'b00, 2'b11, 32, 32);
    checks++;
    if (free_count !== CNT_W'(31)) begin errors++; $display("FAIL chk_same got %0d want 31", free_count); end
    cycle(2'b00, 2'b01, 32, 0);
    checks++;
    if (dbl_free_err !== 1'b1 || free_count !== CNT_W'(32)) begin
      errors++; $display("FAIL chk_sticky got err=%b cnt=%0d want 1/32", dbl_free_err, free_count);
    end
  endtask
`endif

  task automatic test_reset_mid();
    do_reset(2'b00);
    for (int i = 0; i < 5; i++) cycle(2'b11, 2'b00, 0, 0);
    checks++;
    if (free_count !== CNT_W'(22)) begin errors++; $display("FAIL mid_count got %0d want 22", free_count); end
    do_reset(2'b11);
    checks++;
    if (free_count !== CNT_W'(32) || dbl_free_err !== 1'b0) begin
      errors++; $display("FAIL mid_reset got cnt=%0d err=%b want 32/0", free_count, dbl_free_err);
    end
    cycle(2'b01, 2'b00, 0, 0);
    checks++;
    if (obsTag0 !== TAG_W'(32)) begin errors++; $display("FAIL mid_tag got %0d want 32", obsTag0); end
  endtask

  task automatic test_random();
    logic [1:0] req;
    logic [1:0] rv;
    int n;
    int i0;
    int i1;
    int t0;
    int t1;
    do_reset(2'b00);
    for (int c = 0; c < 600; c++) begin
      req = 2'($urandom_range(0, 3));
      n = $urandom_range(0, 2);
      if (n > outq.size()) n = outq.size();
      rv = 2'b00; t0 = 0; t1 = 0;
      if (n == 1) begin
        i0 = $urandom_range(0, outq.size() - 1);
        if ($urandom_range(0, 1) == 1) begin rv = 2'b01; t0 = outq[i0]; end
        else begin rv = 2'b10; t1 = outq[i0]; end
      end else if (n == 2) begin
        i0 = $urandom_range(0, outq.size() - 1);
        i1 = (i0 + 1 + $urandom_range(0, outq.size() - 2)) % outq.size();
        rv = 2'b11; t0 = outq[i0]; t1 = outq[i1];
      end
      cycle(req, rv, t0, t1);
      checks++;
      if (obsGnt !== expGnt) begin errors++; $display("FAIL rnd_gnt c=%0d got %b want %b", c, obsGnt, expGnt); end
      if (expGnt && req[0]) begin
        checks++;
        if (obsTag0 !== TAG_W'(expTag0)) begin
          errors++; $display("FAIL rnd_tag0 c=%0d got %0d want %0d", c, obsTag0, expTag0);
        end
      end
      if (expGnt && req[1]) begin
        checks++;
        if (obsTag1 !== TAG_W'(expTag1)) begin
          errors++; $display("FAIL rnd_tag1 c=%0d got %0d want %0d", c, obsTag1, expTag1);
        end
      end
      checks++;
      if (free_count !== CNT_W'(fq.size()) || empty !== (fq.size() == 0) || dbl_free_err !== mErr) begin
        errors++; $display("FAIL rnd_state c=%0d got cnt=%0d empty=%b err=%b want %0d/%b/%b",
                           c, free_count, empty, dbl_free_err, fq.size(), fq.size() == 0, mErr);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    RST = 1'b1;
    alloc_req = 2'b00;
    rel_valid = 2'b00;
    rel_tag0 = '0;
    rel_tag1 = '0;
    test_reset();
    test_first_alloc();
    test_exhaust();
    test_no_bypass();
    test_wrap();
    test_overflow();
`ifdef PHYS_FREE_LIST_CHECK_EN
    test_check();
`endif
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/phys_reg_free_list.md
# phys_reg_free_list

Physical-register free list for the rename stage. Hands free physical tags to the register renaming unit on allocation requests and takes tags back from the reorder buffer at commit (the old mapping of the retiring destination) or on squash walk-back (the new mapping of squashed instructions). It closes the rename→ROB→rename loop.

## Interface
Parameters:
- NUM_PREGS, 64: physical register count.
- NUM_AREGS, 32: architectural register count; tags 0..NUM_AREGS-1 are never in the list after reset.
- DEPTH, NUM_PREGS-NUM_AREGS: list capacity (derived, not overridable); need not be a power of two.
- TAG_W, $clog2(NUM_PREGS): tag width (derived).

Ports:
- CLK  in  1  clock
- RST  in  1  reset; one clock; reset is synchronous and active-high.
- alloc_req  in  2  per-lane allocation request from RRU (lane 0, lane 1)
- alloc_gnt  out  1  all requested lanes granted this cycle
- alloc_tag0  out  TAG_W  tag for lane 0
- alloc_tag1  out  TAG_W  tag for lane 1
- rel_valid  in  2  per-lane release from ROB
- rel_tag0  in  TAG_W  released tag, lane 0
- rel_tag1  in  TAG_W  released tag, lane 1
- free_count  out  $clog2(DEPTH+1)  entries currently free
- empty  out  1  free_count == 0
- dbl_free_err  out  1  sticky double-release/illegal-tag flag (only with macro, see Configuration)

## Operation
- Storage: ring of DEPTH TAG_W entries, head (read) pointer, tail (write) pointer, count register.
- Reset: entry i = NUM_AREGS+i; head=0, tail=0, count=DEPTH.
- Allocation is all-or-nothing: alloc_gnt=1 iff count ≥ popcount(alloc_req); alloc_req=0 gives alloc_gnt=1 with no state change.
- Lane mapping: lowest requesting lane takes ring[head], the next ring[head+1]. req=2'b10 → alloc_tag1=ring[head], alloc_tag0 don't-care. req=2'b11 → tag0=ring[head], tag1=ring[head+1].
- On grant, head advances by popcount(req); count decrements by the same.
- Release: valid lanes write in lane order at tail, tail+1; tail advances by popcount(rel_valid).
- All pointer increments wrap explicitly: ptr+k ≥ DEPTH → ptr+k−DEPTH.
- Simultaneous alloc and release: count_next = count − granted + released; grant decision uses current count only (no bypass of same-cycle releases).
- Release into a full list (count+released > DEPTH) is a protocol error: the release is dropped and the state is left unchanged; with the macro on, dbl_free_err sets.
- No flush input. The ROB walk-back returns squashed tags through the release port.

## Timing
- alloc_gnt and alloc_tag* are combinational from registered state and alloc_req, valid in the same cycle.
- Pointer, count and storage updates occur at the CLK edge.
- A released tag is allocatable from the next cycle. free_count reflects the edge update.
- Reset values: free_count=DEPTH, empty=0, dbl_free_err=0. alloc_gnt is 1 while RST is high; requests during RST are ignored (no state change).
- Reset mid-operation restores the full initial list regardless of outstanding tags.

## Configuration
- PHYS_FREE_LIST_CHECK_EN defined: a NUM_PREGS-bit in-list vector (reset: bits NUM_AREGS..NUM_PREGS-1 set).
  - Releasing a tag already in the list, a tag < NUM_AREGS, both lanes releasing the same tag, or overflowing the list sets sticky dbl_free_err until RST; the offending release is dropped.
  - Allocation clears the allocated tag's bit.
- Undefined: no vector; dbl_free_err tied 0; releases are trusted, except that overflow is still dropped.

## Structure
- Type package: PhysRegTag typedef (TAG_W bits), NUM_PREGS and NUM_AREGS constants shared with RRU and ROB.
- Packet package: RruToFreeList (alloc_req) and RobToFreeList (rel_valid plus tags) structs for later port bundling.
- One sub-module, free_list_ring: DEPTH-entry 2-read/2-write ring with wrap-aware pointer arithmetic.
- The top module holds grant logic, count and the check vector.

## Test plan
- Reset then alloc_req=2'b11 → gnt=1, tag0=32, tag1=33; next cycle free_count=30.
- 32 single allocations, then req=2'b01 → gnt=0, empty=1, head unchanged. Same cycle release tag 40 → next cycle free_count=1; alloc returns 40.
- Count=1 with req=2'b11 and release of 2 tags in the same cycle → gnt=0 (no bypass); next cycle count=3.
- Wrap: allocate 31, release 31 tags, allocate 2 → head wraps 31→0→1; tags returned in release order.
- Macro on: release tag 45 while still free → dbl_free_err=1 and stays 1; release tag 5 → dropped; free_count unchanged.
- RST asserted after 10 allocations → next cycle free_count=32; first alloc returns 32.
